// File: rtl/out_fm_tile_store_sched.sv
// Output-feature-map tile store scheduler: walks a layer's output tiles in
// (channel, row, column) order and hands each buffered tile to the store path.
module out_fm_tile_store_sched #(
   parameter int CW       = 16,
   parameter int M        = 32,
   parameter int R        = 64,
   parameter int C        = 32,
   parameter int Tm       = 16,
   parameter int Tr       = 64,
   parameter int Tc       = 16,
   parameter int PEND_MAX = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sched_start,
   output logic          sched_busy,
   output logic          sched_done,
   input  logic          tile_ready,
   output logic          buf_release,
   output logic          buf_sel,
   output logic [1:0]    pending,
   output logic          err_overflow,
   output logic          store_start,
   input  logic          store_done,
   output logic [CW-1:0] tile_base_n,
   output logic [CW-1:0] tile_base_row,
   output logic [CW-1:0] tile_base_col
);

   typedef enum logic [2:0] {IDLE, WAIT_TILE, ISSUE, STORING, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    pend_q, pend_d;
   logic          sel_q, sel_d;
   logic          err_q, err_d;
   logic          rel_q, rel_d;
   logic [CW-1:0] n_q, n_d, row_q, row_d, col_q, col_d;

   logic [CW:0]   col_nx, row_nx, n_nx;
   logic          col_wrap, row_wrap, last_tile, sd_acc;

   // One spare bit so base + step cannot wrap before the bound compare.
   assign col_nx    = {1'b0, col_q} + (CW+1)'(Tc);
   assign row_nx    = {1'b0, row_q} + (CW+1)'(Tr);
   assign n_nx      = {1'b0, n_q} + (CW+1)'(Tm);
   assign col_wrap  = (col_nx >= (CW+1)'(C));
   assign row_wrap  = (row_nx >= (CW+1)'(R));
   assign last_tile = col_wrap && row_wrap && (n_nx >= (CW+1)'(M));
   assign sd_acc    = store_done && (state_q == STORING);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      sel_d   = sel_q;
      err_d   = err_q;
      rel_d   = 1'b0;
      n_d     = n_q;
      row_d   = row_q;
      col_d   = col_q;

      if (state_q != IDLE) begin
         if (tile_ready && !sd_acc) begin
            if (pend_q == 2'(PEND_MAX)) err_d = 1'b1;
            else                        pend_d = pend_q + 2'd1;
         end else if (!tile_ready && sd_acc) begin
            pend_d = pend_q - 2'd1;
         end
      end

      case (state_q)
         IDLE: begin
            if (sched_start) begin
               n_d     = '0;
               row_d   = '0;
               col_d   = '0;
               pend_d  = '0;
               sel_d   = 1'b0;
               err_d   = 1'b0;
               state_d = WAIT_TILE;
            end
         end
         WAIT_TILE: if (pend_q != 2'd0) state_d = ISSUE;
         ISSUE:     state_d = STORING;
         STORING: begin
            if (sd_acc) begin
               rel_d = 1'b1;
               sel_d = ~sel_q;
               if (col_wrap) begin
                  col_d = '0;
                  if (row_wrap) begin
                     row_d = '0;
                     n_d   = last_tile ? '0 : n_nx[CW-1:0];
                  end else begin
                     row_d = row_nx[CW-1:0];
                  end
               end else begin
                  col_d = col_nx[CW-1:0];
               end
               state_d = last_tile ? DONE : WAIT_TILE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         sel_q   <= 1'b0;
         err_q   <= 1'b0;
         rel_q   <= 1'b0;
         n_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
         rel_q   <= rel_d;
         n_q     <= n_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   assign sched_busy    = (state_q != IDLE);
   assign sched_done    = (state_q == DONE);
   assign store_start   = (state_q == ISSUE);
   assign buf_release   = rel_q;
   assign buf_sel       = sel_q;
   assign pending       = pend_q;
   assign err_overflow  = err_q;
   assign tile_base_n   = n_q;
   assign tile_base_row = row_q;
   assign tile_base_col = col_q;

endmodule

// File: tb/tb_out_fm_tile_store_sched.sv
// Bench for out_fm_tile_store_sched: default-geometry instance driven by random
// and directed traffic, plus a 40-channel instance for the partial-tile walk.
module tb_out_fm_tile_store_sched;

   localparam int CW  = 16;
   localparam int M0  = 32, R0 = 64, C0 = 32, TM0 = 16, TR0 = 64, TC0 = 16;
   localparam int M1  = 40, R1 = 16, C1 = 16, TM1 = 16, TR1 = 16, TC1 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, st0, tr0, sd_man, sd_auto, sd0;
   logic          busy_0, done_0, rel_0, bsel_0, err_0, ss_0;
   logic [1:0]    pend_0;
   logic [CW-1:0] bn_0, br_0, bc_0;

   logic          st1, tr1, sd1;
   logic          busy_1, done_1, rel_1, bsel_1, err_1, ss_1;
   logic [1:0]    pend_1;
   logic [CW-1:0] bn_1, br_1, bc_1;

   assign sd0 = sd_man | sd_auto;

   out_fm_tile_store_sched #(.CW(CW), .M(M0), .R(R0), .C(C0), .Tm(TM0), .Tr(TR0), .Tc(TC0), .PEND_MAX(2)) dut0 (
      .clk(clk), .rst(rst), .sched_start(st0), .sched_busy(busy_0), .sched_done(done_0),
      .tile_ready(tr0), .buf_release(rel_0), .buf_sel(bsel_0), .pending(pend_0),
      .err_overflow(err_0), .store_start(ss_0), .store_done(sd0),
      .tile_base_n(bn_0), .tile_base_row(br_0), .tile_base_col(bc_0));

   out_fm_tile_store_sched #(.CW(CW), .M(M1), .R(R1), .C(C1), .Tm(TM1), .Tr(TR1), .Tc(TC1), .PEND_MAX(2)) dut1 (
      .clk(clk), .rst(rst), .sched_start(st1), .sched_busy(busy_1), .sched_done(done_1),
      .tile_ready(tr1), .buf_release(rel_1), .buf_sel(bsel_1), .pending(pend_1),
      .err_overflow(err_1), .store_start(ss_1), .store_done(sd1),
      .tile_base_n(bn_1), .tile_base_row(br_1), .tile_base_col(bc_1));

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [63:0] outs0();
      return {8'd0, busy_0, done_0, rel_0, bsel_0, pend_0, err_0, ss_0, bn_0, br_0, bc_0};
   endfunction

   function automatic logic [63:0] outs1();
      return {8'd0, busy_1, done_1, rel_1, bsel_1, pend_1, err_1, ss_1, bn_1, br_1, bc_1};
   endfunction

   // Event log of dut0, one entry per clock cycle that just ended.
   int          cyc = 0, ss_cnt = 0, rel_cnt = 0, done_cnt = 0, sd_cyc = -10, done_cyc = -20;
   logic [47:0] ss_base_q[$];
   logic        ss_sel_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ss_0) begin
         ss_base_q.push_back({bn_0, br_0, bc_0});
         ss_sel_q.push_back(bsel_0);
         ss_cnt <= ss_cnt + 1;
      end
      if (rel_0)  rel_cnt <= rel_cnt + 1;
      if (done_0) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (sd0) sd_cyc <= cyc;
   end

   // Store-path model: answers each store_start after a latency in [lat_lo, lat_hi].
   int lat_lo = 20, lat_hi = 20, sm_cnt = 0;
   bit auto_en = 1'b0;

   initial begin
      sd_auto = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         sd_auto = 1'b0;
         if (sm_cnt > 0) begin
            sm_cnt--;
            if (sm_cnt == 0) sd_auto = 1'b1;
         end else if (auto_en && ss_0) begin
            sm_cnt = int'($urandom_range(lat_hi, lat_lo));
         end
      end
   end

   task automatic run_layer0(input int gap_lo, input int gap_hi, input string tag);
      logic [47:0] exp_q[$];
      int s0, r0, d0, sent, wt;
      for (int n = 0; n < M0; n += TM0)
         for (int r = 0; r < R0; r += TR0)
            for (int c = 0; c < C0; c += TC0)
               exp_q.push_back({CW'(n), CW'(r), CW'(c)});
      ss_base_q.delete();
      ss_sel_q.delete();
      s0 = ss_cnt; r0 = rel_cnt; d0 = done_cnt; sent = 0;
      auto_en = 1'b1;
      st0 = 1'b1; tick(); st0 = 1'b0;
      chk({tag, "_busy_after_start"}, busy_0, 1);
      for (int i = 0; i < int'(exp_q.size()); i++) begin
         tick(int'($urandom_range(gap_hi, gap_lo)));
         wt = 0;
         while ((sent - (rel_cnt - r0) - int'(rel_0)) >= 2 && wt < 500) begin
            tick();
            wt++;
         end
         chk({tag, "_credit_wait"}, (wt < 500), 1);
         tr0 = 1'b1; tick(); tr0 = 1'b0;
         sent++;
         chk({tag, "_pending"}, pend_0, sent - (rel_cnt - r0) - int'(rel_0));
      end
      wt = 0;
      while (done_cnt == d0 && wt < 3000) begin
         tick();
         wt++;
      end
      chk({tag, "_done_seen"}, done_cnt - d0, 1);
      chk({tag, "_done_timing"}, done_cyc - sd_cyc, 1);
      chk({tag, "_busy_after_done"}, busy_0, 0);
      chk({tag, "_pending_end"}, pend_0, 0);
      chk({tag, "_no_overflow"}, err_0, 0);
      chk({tag, "_store_starts"}, ss_cnt - s0, exp_q.size());
      chk({tag, "_releases"}, rel_cnt - r0, exp_q.size());
      for (int i = 0; i < int'(exp_q.size()); i++) begin
         chk({tag, "_base"}, (i < int'(ss_base_q.size())) ? ss_base_q[i] : 48'hFFFF_FFFF_FFFF, exp_q[i]);
         chk({tag, "_buf_sel"}, (i < int'(ss_sel_q.size())) ? ss_sel_q[i] : 1'bx, i % 2);
      end
      auto_en = 1'b0;
   endtask

   initial begin
      logic [47:0] exp1[$];
      int s0, r0, wt;
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] exp1[$];
      int s0, r0, wt;
      rst = 1'b1; st0 = 1'b0; tr0 = 1'b0; sd_man = 1'b0;
      st1 = 1'b0; tr1 = 1'b0; sd1 = 1'b0;
      tick(3);
      chk("reset_outs0", outs0(), 0);
      chk("reset_outs1", outs1(), 0);
      rst = 1'b0;
      tick();

      lat_lo = 20; lat_hi = 20;
      run_layer0(49, 49, "base");
      lat_lo = 1; lat_hi = 25;
      for (int k = 0; k < 3; k++) run_layer0(0, 30, "rand");

      // Burst into full buffers, then tile_ready together with store_done.
      tick(30);
      st0 = 1'b1; tick(); st0 = 1'b0;
      s0 = ss_cnt;
      tr0 = 1'b1; tick(3); tr0 = 1'b0;
      chk("burst_pending", pend_0, 2);
      chk("burst_err", err_0, 1);
      tick(5);
      chk("burst_store_starts", ss_cnt - s0, 1);
      tr0 = 1'b1; sd_man = 1'b1; tick(); tr0 = 1'b0; sd_man = 1'b0;
      chk("same_cycle_pending", pend_0, 2);
      chk("same_cycle_release", rel_0, 1);
      chk("same_cycle_err_sticky", err_0, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("reset_mid_outs", outs0(), 0);

      // Stray store_done and sched_start while waiting for a tile.
      st0 = 1'b1; tick(); st0 = 1'b0;
      tick(2);
      r0 = rel_cnt;
      sd_man = 1'b1; st0 = 1'b1; tick(); sd_man = 1'b0; st0 = 1'b0;
      chk("stray_busy", busy_0, 1);
      chk("stray_release", rel_0, 0);
      chk("stray_bases", {bn_0, br_0, bc_0}, 0);
      chk("stray_pending", pend_0, 0);
      tick(3);
      chk("stray_release_cnt", rel_cnt - r0, 0);
      chk("stray_store_start", ss_0, 0);
      tr0 = 1'b1; tick(); tr0 = 1'b0;
      chk("ready_pending_t1", pend_0, 1);
      chk("ready_no_issue_t1", ss_0, 0);
      tick();
      chk("ready_issue_t2", ss_0, 1);
      tick();
      st0 = 1'b1; tick(); st0 = 1'b0;
      tick(2);
      chk("hold_bases", {bn_0, br_0, bc_0}, 0);
      chk("hold_busy", busy_0, 1);
      sd_man = 1'b1; tick(); sd_man = 1'b0;
      chk("advance_release", rel_0, 1);
      chk("advance_bases", {bn_0, br_0, bc_0}, {CW'(0), CW'(0), CW'(TC0)});
      chk("advance_buf_sel", bsel_0, 1);
      chk("advance_pending", pend_0, 0);
      rst = 1'b1; tick(); rst = 1'b0;

      // Reset one cycle after the second store_start; the late store_done must be ignored.
      lat_lo = 20; lat_hi = 20; auto_en = 1'b1;
      st0 = 1'b1; tick(); st0 = 1'b0;
      s0 = ss_cnt;
      tr0 = 1'b1; tick(); tr0 = 1'b0;
      tick(2);
      tr0 = 1'b1; tick(); tr0 = 1'b0;
      wt = 0;
      while ((ss_cnt - s0) < 2 && wt < 200) begin
         tick();
         wt++;
      end
      chk("rst2_second_start", ss_cnt - s0, 2);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst2_outs", outs0(), 0);
      r0 = rel_cnt;
      tick(40);
      chk("rst2_no_release", rel_cnt - r0, 0);
      chk("rst2_idle", busy_0, 0);
      auto_en = 1'b0;

      // 40 channels in 16-channel tiles: last tile is a partial edge tile.
      for (int n = 0; n < M1; n += TM1)
         for (int r = 0; r < R1; r += TR1)
            for (int c = 0; c < C1; c += TC1)
               exp1.push_back({CW'(n), CW'(r), CW'(c)});
      st1 = 1'b1; tick(); st1 = 1'b0;
      chk("m40_busy", busy_1, 1);
      for (int i = 0; i < int'(exp1.size()); i++) begin
         tr1 = 1'b1; tick(); tr1 = 1'b0;
         wt = 0;
         while (!ss_1 && wt < 10) begin
            tick();
            wt++;
         end
         chk("m40_store_start", ss_1, 1);
         chk("m40_base", {bn_1, br_1, bc_1}, exp1[i]);
         tick(4);
         sd1 = 1'b1; tick(); sd1 = 1'b0;
         chk("m40_release", rel_1, 1);
         chk("m40_done", done_1, (i == int'(exp1.size()) - 1));
      end
      tick();
      chk("m40_busy_end", busy_1, 0);
      chk("m40_pending_end", pend_1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
